ste_avg_iir_mc: RTL and testbench
=================================

# ste_avg_iir_mc

Multi-channel, time-multiplexed first-order IIR averager (exponential moving average) for the multimeter measurement path. It sits between the ADC sample sequencer and the display/statistics logic. Each of `CH_N` channels keeps its own filter state with extra fractional bits. The smoothing factor is a runtime power of two, 2^-k. The block adds valid/channel tagging, first-sample seeding, global clear and per-sample bypass.

## Interface
- `DATA_W`, 16: sample and output width, unsigned.
- `CH_N`, 4: number of channels (≥1).
- `CH_W`, `$clog2(CH_N)` (min 1): channel index width.
- `FRAC_W`, 8: fractional guard bits kept in each channel state (≥1).
- `K_W`, 4: width of the shift-select input.
- `MAX_K`, 12: largest shift applied; larger requests are clamped to this value.
- `clk`  in  1  system clock; all logic is clocked on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `din_i`  in  DATA_W  input sample.
- `din_ch_i`  in  CH_W  channel of `din_i`.
- `din_vld_i`  in  1  sample strobe, one sample per cycle max.
- `k_i`  in  K_W  shift for this sample; alpha = 2^-k.
- `avg_en_i`  in  1  1 = filter, 0 = bypass (sampled with `din_vld_i`).
- `avg_clr_i`  in  1  clear all channel states and seeded flags.
- `dout_o`  out  DATA_W  averaged value for `dout_ch_o`.
- `dout_ch_o`  out  CH_W  channel tag of `dout_o`.
- `dout_vld_o`  out  1  one-cycle strobe; `dout_o` and `dout_ch_o` are valid.

## Operation
- Per-channel state `s[c]` has width DATA_W+FRAC_W, unsigned, scaled by 2^FRAC_W. Each channel also has a flag `seeded[c]`.
- For an accepted sample: `x = din_i << FRAC_W`, `ke = min(k_i, MAX_K)`.
- Update rules, evaluated in order:
  - Channel not seeded, or `avg_en_i` = 0: `s_new = x` and `seeded[c]` is set (seed / bypass).
  - Otherwise: `d = x - s[c]` as a signed (DATA_W+FRAC_W+1)-bit value; `s_new = s[c] + (d >>> ke)`. The shift is arithmetic and floors.
- `s_new` always lies between `s[c]` and `x`. No overflow or saturation logic is needed.
- Output: `dout_o = (s_new + 2^(FRAC_W-1)) >> FRAC_W`, i.e. round half up. This cannot exceed 2^DATA_W-1.
- `ke` = 0 gives output equal to `din_i`.
- With a constant input and `ke` ≤ FRAC_W-1, the output settles to exactly `din_i`.
- `din_ch_i` ≥ CH_N: the sample is dropped. No state change and no `dout_vld_o`.
- `avg_clr_i`: all `s` are set to 0 and all `seeded` flags are cleared.
- `avg_clr_i` together with `din_vld_i` in the same cycle: the clear is applied first. The sample then seeds its channel, and `dout_o = din_i`.
- `avg_clr_i` alone produces no output strobe.
- Samples to other channels never touch the state of channel c.

## Timing
- Latency is 1 cycle: sample at edge n produces `dout_vld_o`, `dout_o`, `dout_ch_o` registered at edge n+1.
- Throughput is 1 sample per cycle.
- Back-to-back samples on the same channel are fully supported. Cycle n+1 sees the state written at edge n+1, with no stall and no hazard.
- `dout_vld_o` is high for exactly one cycle per accepted sample.
- `dout_o` and `dout_ch_o` hold their last value while `dout_vld_o` = 0.
- Reset: `dout_o` = 0, `dout_ch_o` = 0, `dout_vld_o` = 0, all `s` = 0, all `seeded` = 0.
- A sample presented in the reset cycle is discarded.
- Reset asserted mid-stream: the next sample on any channel after reset seeds that channel.

## Test plan
(Defaults: DATA_W=16, FRAC_W=8.)
- **Seed after reset:** ch0 `din`=1000, `k`=2, `en`=1 -> next cycle `dout_vld`=1, `dout`=1000, `dout_ch`=0.
- **Step response:** seed ch0 with 0, then four samples of 1024 with `k`=2 -> `dout` = 256, 448, 592, 700. Continue with 1024 -> settles to exactly 1024.
- **Channel independence:** interleave ch1 `din`=4000 and ch2 `din`=100 with `k`=3, back to back -> each channel's outputs match its own single-channel model.
  - ch3 is never written and seeds with its first sample.
  - `din_ch`=5 with CH_N=4 -> no `dout_vld`.
- **Clear:**
  - ch0 settled at 1024; assert `avg_clr` with ch0 `din`=50 -> `dout`=50.
  - `avg_clr` alone -> no strobe; ch1's next sample of 77 gives `dout`=77.
- **Bypass and shift clamp:**
  - `en`=0, ch0 `din` = 10, 20, 30 -> `dout` = 10, 20, 30.
  - Then `en`=1, `din`=30, `k`=15 with `MAX_K`=12 -> `dout`=30.
  - Then `din`=4126 -> `dout`=31, which is the clamped shift of 12 (with `k`=15 it would be 30).
- **Full scale and reset mid-stream:**
  - Seed 65535 with `k`=1 and hold -> `dout` stays 65535.
  - Assert `rst` between two samples -> outputs are 0, and the next sample of 12 gives `dout`=12.

Source files
------------

// File: rtl/ste_avg_iir_mc.sv
// Multi-channel time-multiplexed exponential moving average, alpha = 2^-k.
// One shared datapath, per-channel fixed-point state with FRAC_W guard bits.
module ste_avg_iir_mc #(
    parameter int DATA_W = 16,
    parameter int CH_N   = 4,
    parameter int CH_W   = (CH_N > 1) ? $clog2(CH_N) : 1,
    parameter int FRAC_W = 8,
    parameter int K_W    = 4,
    parameter int MAX_K  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din_i,
    input  logic [CH_W-1:0]   din_ch_i,
    input  logic              din_vld_i,
    input  logic [K_W-1:0]    k_i,
    input  logic              avg_en_i,
    input  logic              avg_clr_i,
    output logic [DATA_W-1:0] dout_o,
    output logic [CH_W-1:0]   dout_ch_o,
    output logic              dout_vld_o
);

    localparam int S_W = DATA_W + FRAC_W;
    localparam logic [CH_W:0]    CH_LIM = (CH_W + 1)'(CH_N);
    localparam logic [K_W-1:0]   K_MAX  = K_W'(MAX_K);
    localparam logic [S_W-1:0]   HALF   = S_W'(1) << (FRAC_W - 1);

    logic [S_W-1:0]   s_q [CH_N];
    logic [CH_N-1:0]  seeded_q;

    logic                ch_ok;
    logic                accept;
    logic                seeded_cur;
    logic [S_W-1:0]      s_cur;
    logic [S_W-1:0]      x;
    logic [S_W-1:0]      s_new;
    logic [S_W-1:0]      rnd;
    logic [K_W-1:0]      ke;
    logic signed [S_W:0] d;
    logic signed [S_W:0] d_sh;

    always_comb begin
        ch_ok      = {1'b0, din_ch_i} < CH_LIM;
        accept     = din_vld_i && ch_ok;
        s_cur      = '0;
        seeded_cur = 1'b0;
        for (int c = 0; c < CH_N; c++) begin
            if (din_ch_i == CH_W'(c)) begin
                s_cur      = s_q[c];
                seeded_cur = seeded_q[c];
            end
        end
        x    = {din_i, {FRAC_W{1'b0}}};
        ke   = (k_i > K_MAX) ? K_MAX : k_i;
        d    = $signed({1'b0, x}) - $signed({1'b0, s_cur});
        d_sh = d >>> ke;
        // A clear in the same cycle leaves the channel unseeded, so the sample seeds it.
        if (avg_clr_i || !seeded_cur || !avg_en_i) begin
            s_new = x;
        end else begin
            s_new = s_cur + S_W'(d_sh);
        end
        rnd = s_new + HALF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH_N; c++) begin
                s_q[c] <= '0;
            end
            seeded_q   <= '0;
            dout_o     <= '0;
            dout_ch_o  <= '0;
            dout_vld_o <= 1'b0;
        end else begin
            dout_vld_o <= accept;
            for (int c = 0; c < CH_N; c++) begin
                if (avg_clr_i) begin
                    s_q[c]      <= '0;
                    seeded_q[c] <= 1'b0;
                end
                if (accept && din_ch_i == CH_W'(c)) begin
                    s_q[c]      <= s_new;
                    seeded_q[c] <= 1'b1;
                end
            end
            if (accept) begin
                dout_o    <= DATA_W'(rnd >> FRAC_W);
                dout_ch_o <= din_ch_i;
            end
        end
    end

endmodule

// File: tb/tb_ste_avg_iir_mc.sv
// Directed plus randomized check of ste_avg_iir_mc against an integer EMA model.
// CH_W is widened to 3 so that out-of-range channel numbers can be driven.
module tb_ste_avg_iir_mc;

    localparam int DATA_W = 16;
    localparam int CH_N   = 4;
    localparam int CH_W   = 3;
    localparam int FRAC_W = 8;
    localparam int K_W    = 4;
    localparam int MAX_K  = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] din_i;
    logic [CH_W-1:0]   din_ch_i;
    logic              din_vld_i;
    logic [K_W-1:0]    k_i;
    logic              avg_en_i;
    logic              avg_clr_i;
    logic [DATA_W-1:0] dout_o;
    logic [CH_W-1:0]   dout_ch_o;
    logic              dout_vld_o;

    ste_avg_iir_mc #(
        .DATA_W(DATA_W), .CH_N(CH_N), .CH_W(CH_W),
        .FRAC_W(FRAC_W), .K_W(K_W), .MAX_K(MAX_K)
    ) dut (
        .clk(clk), .rst(rst),
        .din_i(din_i), .din_ch_i(din_ch_i), .din_vld_i(din_vld_i),
        .k_i(k_i), .avg_en_i(avg_en_i), .avg_clr_i(avg_clr_i),
        .dout_o(dout_o), .dout_ch_o(dout_ch_o), .dout_vld_o(dout_vld_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: real-valued average kept as an integer scaled by 2^FRAC_W.
    int m_s [CH_N];
    bit m_seeded [CH_N];
    int m_dout = 0;
    int m_ch   = 0;
    bit m_vld  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH_N; c++) begin
            m_s[c]      = 0;
            m_seeded[c] = 0;
        end
    endtask

    task automatic model_sample(input bit v, input int ch, input int din, input int k,
                                input bit en, input bit clr);
        int x, ke, d, p, q;
        if (clr) model_clear();
        m_vld = 0;
        if (v && ch < CH_N) begin
            x  = din * (1 << FRAC_W);
            ke = (k > MAX_K) ? MAX_K : k;
            if (!m_seeded[ch] || !en) begin
                m_s[ch] = x;
            end else begin
                d = x - m_s[ch];
                p = 1 << ke;
                q = d / p;
                if (d < 0 && q * p != d) q = q - 1;
                m_s[ch] = m_s[ch] + q;
            end
            m_seeded[ch] = 1;
            m_dout = (m_s[ch] + (1 << (FRAC_W - 1))) / (1 << FRAC_W);
            m_ch   = ch;
            m_vld  = 1;
        end
    endtask

    task automatic cyc(input bit v, input int ch, input int din, input int k,
                       input bit en, input bit clr, input string tag);
        din_vld_i = v;
        din_ch_i  = ch[CH_W-1:0];
        din_i     = din[DATA_W-1:0];
        k_i       = k[K_W-1:0];
        avg_en_i  = en;
        avg_clr_i = clr;
        @(posedge clk);
        model_sample(v, ch, din, k, en, clr);
        #1;
        chk({tag, ".vld"}, int'(dout_vld_o), int'(m_vld));
        chk({tag, ".dout"}, int'(dout_o), m_dout);
        chk({tag, ".ch"}, int'(dout_ch_o), m_ch);
        din_vld_i = 1'b0;
        avg_clr_i = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b1;
        din_vld_i = 1'b1;
        din_ch_i  = '0;
        din_i     = 16'd999;
        k_i       = '0;
        avg_en_i  = 1'b1;
        avg_clr_i = 1'b0;
        @(posedge clk);
        model_clear();
        m_dout = 0;
        m_ch   = 0;
        m_vld  = 0;
        #1;
        chk({tag, ".vld"}, int'(dout_vld_o), 0);
        chk({tag, ".dout"}, int'(dout_o), 0);
        chk({tag, ".ch"}, int'(dout_ch_o), 0);
        rst       = 1'b0;
        din_vld_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        int steps [4];
        steps = '{256, 448, 592, 700};

        do_reset("rst0");

        cyc(1, 0, 1000, 2, 1, 0, "seed");
        chk("seed.const", int'(dout_o), 1000);

        cyc(1, 0, 0, 2, 0, 0, "step0");
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1024, 2, 1, 0, "step");
            chk("step.const", int'(dout_o), steps[i]);
        end
        for (int i = 0; i < 30; i++) cyc(1, 0, 1024, 2, 1, 0, "settle");
        chk("settle.const", int'(dout_o), 1024);

        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 4000, 3, 1, 0, "ilv1");
            cyc(1, 2, 100, 3, 1, 0, "ilv2");
        end
        cyc(1, 3, 500, 3, 1, 0, "ch3seed");
        chk("ch3seed.const", int'(dout_o), 500);
        cyc(1, 5, 321, 3, 1, 0, "badch");
        chk("badch.const", int'(dout_vld_o), 0);
        cyc(0, 0, 0, 0, 1, 0, "idle");

        cyc(1, 0, 50, 2, 1, 1, "clrsamp");
        chk("clrsamp.const", int'(dout_o), 50);
        cyc(0, 0, 0, 0, 1, 1, "clronly");
        chk("clronly.const", int'(dout_vld_o), 0);
        cyc(1, 1, 77, 3, 1, 0, "postclr");
        chk("postclr.const", int'(dout_o), 77);

        cyc(1, 0, 10, 2, 0, 0, "byp10");
        chk("byp10.const", int'(dout_o), 10);
        cyc(1, 0, 20, 2, 0, 0, "byp20");
        chk("byp20.const", int'(dout_o), 20);
        cyc(1, 0, 30, 2, 0, 0, "byp30");
        chk("byp30.const", int'(dout_o), 30);
        cyc(1, 0, 30, 15, 1, 0, "clamp30");
        chk("clamp30.const", int'(dout_o), 30);
        cyc(1, 0, 4126, 15, 1, 0, "clamp");
        chk("clamp.const", int'(dout_o), 31);

        cyc(1, 2, 65535, 1, 0, 0, "fs_seed");
        for (int i = 0; i < 5; i++) cyc(1, 2, 65535, 1, 1, 0, "fs_hold");
        chk("fs_hold.const", int'(dout_o), 65535);

        do_reset("rst1");
        cyc(1, 2, 12, 1, 1, 0, "rst_seed");
        chk("rst_seed.const", int'(dout_o), 12);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, int'($urandom_range(0, 5)),
                (($urandom % 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(1000, 1100)),
                int'($urandom_range(0, 15)), ($urandom % 8) != 0, ($urandom % 40) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
